mk_hardware: RTL and testbench

// - Put/Get elastic buffer between a producer and a consumer on one clock domain.
// - Producer side:
//   - 32-bit words are accepted through a Bluespec-style put method (EN_put/RDY_put).
//   - Each word is stored in a circular FIFO.
// - Consumer side:
//   - The FIFO head, plus a fixed offset, is presented through a get method (EN_get/RDY_get).
// - Decouples producer and consumer rates; gives backpressure when full and stalls when empty.
//

---
 rtl/mk_hardware.sv | 65 ++++++
 tb/tb_mk_hardware.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mk_hardware.sv
// Put/Get elastic buffer: a circular FIFO of 32-bit words. The producer enqueues
// through put (EN_put/RDY_put); the consumer sees the head word plus a fixed
// OFFSET on get and dequeues with EN_get/RDY_get. The ready flags depend only
// on registered state, so the environment may form EN_* = want && RDY_*.
module mk_hardware #(
  parameter int unsigned DEPTH  = 4,
  parameter logic [31:0] OFFSET = 32'h0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] put_datas,
  input  logic        EN_put,
  output logic        RDY_put,
  output logic [31:0] get,
  input  logic        EN_get,
  output logic        RDY_get
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_put;
  logic          do_get;

  assign RDY_put = (count != FULL_COUNT);
  assign RDY_get = (count != '0);

  // Strobes take effect only while the matching ready flag is high.
  assign do_put = EN_put && RDY_put;
  assign do_get = EN_get && RDY_get;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (do_put) mem[wr_ptr] <= put_datas;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_put) wr_ptr <= wr_ptr + PW'(1);
      if (do_get) rd_ptr <= rd_ptr + PW'(1);
      case ({do_put, do_get})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head word plus offset (carry discarded); zero while empty.
  always_comb begin
    get = '0;
    if (RDY_get) get = mem[rd_ptr] + OFFSET;
  end

endmodule

// File: tb/tb_mk_hardware.sv
// Bench for mk_hardware: a driver issues put/get traffic and records every
// accepted put in an expected-word queue (the FIFO reference model); a monitor
// at each falling edge checks the flags and head value against that queue and
// pops it on every accepted get.
module tb_mk_hardware;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] OFFSET = 32'h0;

  logic        CLK;
  logic        RST_N;
  logic [31:0] put_datas;
  logic        EN_put;
  logic        RDY_put;
  logic [31:0] get;
  logic        EN_get;
  logic        RDY_get;

  int checks = 0;
  int errors = 0;
  int n_gets = 0;
  logic [31:0] exp_q[$];

  mk_hardware #(.DEPTH(DEPTH), .OFFSET(OFFSET)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .put_datas (put_datas),
    .EN_put    (EN_put),
    .RDY_put   (RDY_put),
    .get       (get),
    .EN_get    (EN_get),
    .RDY_get   (RDY_get)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: flags and head value versus the model; pop on accepted get.
  always @(negedge CLK) begin
    chk("rdy_put", {31'b0, RDY_put}, {31'b0, exp_q.size() != DEPTH});
    chk("rdy_get", {31'b0, RDY_get}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() == 0) begin
      chk("get_empty", get, 32'h0);
    end else begin
      chk("get_head", get, exp_q[0]);
      if (EN_get === 1'b1) begin
        void'(exp_q.pop_front());
        n_gets++;
      end
    end
  end

  // One cycle of stimulus, called just after a rising edge. A put is accepted
  // by the model only if the buffer held fewer than DEPTH words this cycle.
  task automatic step(input logic p, input logic [31:0] d, input logic g);
    logic acc;
    EN_put    = p;
    put_datas = d;
    EN_get    = g;
    acc = p && (exp_q.size() < DEPTH);
    @(posedge CLK);
    #1;
    if (acc) exp_q.push_back(d + OFFSET);
  endtask

  task automatic do_reset(input int unsigned n);
    RST_N  = 1'b0;
    EN_put = 1'b0;
    EN_get = 1'b0;
    #1;
    chk("rst_rdy_put", {31'b0, RDY_put}, 32'h1);
    chk("rst_rdy_get", {31'b0, RDY_get}, 32'h0);
    chk("rst_get", get, 32'h0);
    exp_q.delete();
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    for (int unsigned i = 0; i < 4 * DEPTH && exp_q.size() != 0; i++) step(1'b0, 32'h0, 1'b1);
    chk("drained", exp_q.size(), 32'h0);
  endtask

  initial begin
    int unsigned puts_done;
    int unsigned gets_start;
    RST_N     = 1'b0;
    EN_put    = 1'b0;
    EN_get    = 1'b0;
    put_datas = '0;
    @(posedge CLK);
    #1;

    // Reset held for 5 cycles, then released.
    do_reset(5);

    // Single word, then dequeue.
    step(1'b1, 32'h4, 1'b0);
    chk("single_rdy_get", {31'b0, RDY_get}, 32'h1);
    chk("single_get", get, 32'h4 + OFFSET);
    step(1'b0, 32'h0, 1'b1);
    chk("single_empty", {31'b0, RDY_get}, 32'h0);

    // Fill to full, one ignored put, then drain including one ignored get.
    for (int unsigned i = 0; i < 4; i++) step(1'b1, 32'(4 * i), 1'b0);
    chk("full_rdy_put", {31'b0, RDY_put}, 32'h0);
    step(1'b1, 32'd16, 1'b0);
    gets_start = n_gets;
    for (int unsigned i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
    chk("fill_gets", n_gets - gets_start, 32'd4);

    // Concurrent random traffic, six words 0..20, each strobe gated by its RDY.
    puts_done  = 0;
    gets_start = n_gets;
    for (int unsigned c = 0; c < 300 && (puts_done < 6 || n_gets - gets_start < 6); c++) begin
      logic p;
      logic g;
      p = (puts_done < 6) && ($urandom_range(0, 1) == 1) && RDY_put;
      g = ($urandom_range(0, 1) == 1) && RDY_get;
      step(p, 32'(4 * puts_done), g);
      if (p) puts_done++;
    end
    chk("conc_puts", puts_done, 32'd6);
    chk("conc_gets", n_gets - gets_start, 32'd6);

    // Simultaneous put+get at two words held; pointers wrap repeatedly.
    step(1'b1, 32'hA000_0000, 1'b0);
    step(1'b1, 32'hA000_0001, 1'b0);
    for (int unsigned i = 2; i < 12; i++) begin
      step(1'b1, 32'hA000_0000 + i, 1'b1);
      chk("simul_count", exp_q.size(), 32'd2);
    end
    drain();

    // Mid-operation asynchronous reset with three words queued.
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 32'hB0 + i, 1'b0);
    #2;
    do_reset(2);
    step(1'b1, 32'h7, 1'b0);
    chk("after_rst_get", get, 32'h7 + OFFSET);
    drain();

    // Randomized data and strobes, including ignored puts when full and gets when empty.
    for (int unsigned c = 0; c < 400; c++) begin
      step($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) == 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
